dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: M0, the CPU load/store port, and M1, a debug/DMA port used for program load and memory inspection.
- Per-beat round-robin arbitration, with an optional M1 lock for atomic multi-beat sequences.
- A starvation guard breaks the lock if the CPU waits too long.
- Sits between the CPU data port and the dmem address/write-data/write-enable pins. Read data from dmem is combinational and is registered here.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- STARVE_MAX, 16, maximum consecutive cycles M0 may be blocked by an M1 lock before the lock is broken. Legal range 1..255.
- CW, 8, width of the starvation counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- m0_req  in  1  M0 access request, held until granted.
- m0_we  in  1  M0 write (1) / read (0).
- m0_addr  in  AW  M0 byte address.
- m0_wdata  in  DW  M0 write data.
- m0_gnt  out  1  M0 access performed this cycle.
- m0_rvalid  out  1  M0 read data valid (cycle after a read grant).
- m0_rdata  out  DW  M0 read data.
- m1_req, m1_we, m1_addr, m1_wdata  in  1/1/AW/DW  M1 request, same meaning as M0.
- m1_lock  in  1  M1 requests to keep ownership after its current grant.
- m1_gnt, m1_rvalid, m1_rdata  out  1/1/DW  same meaning as M0.
- lock_broken  out  1  one-cycle pulse when the starvation guard ends an M1 lock.
- mem_we  out  1  dmem write enable.
- mem_addr  out  AW  dmem address.
- mem_wdata  out  DW  dmem write data.
- mem_rdata  in  DW  dmem combinational read data.

Behaviour:
- States:
  - IDLE_P0: M0 has priority.
  - IDLE_P1: M1 has priority.
  - LOCKED: M1 owns the memory.
  - Reset state is IDLE_P0.
- Grant is combinational from the state and the requests; at most one gnt is high per cycle.
  - IDLE_Px, one requester: it is granted.
  - IDLE_Px, both requesting: the priority holder is granted.
  - LOCKED: only M1 may be granted; m0_gnt=0.
  - Exception: the forced-M0 cycle described below.
- Memory drive:
  - mem_addr and mem_wdata come from the granted master.
  - With no grant, they hold the M0 values.
  - mem_we = granted master's we AND gnt; mem_we is never high without a grant.
- Read return:
  - On a read grant, mem_rdata is captured into that master's rdata register at the clock edge.
  - mx_rvalid is high for exactly the next cycle.
  - mx_rdata holds its value until the next read for that master.
  - Write grants produce no rvalid.
- Transitions, evaluated at the clock edge:
  - Grant to M0 → IDLE_P1.
  - Grant to M1 with m1_lock=0 → IDLE_P0.
  - Grant to M1 with m1_lock=1 → LOCKED.
  - In LOCKED with m1_lock=0 → IDLE_P0. A grant may still occur in this cycle.
  - No grant in IDLE → state unchanged.
- Starvation counter:
  - Cleared outside LOCKED.
  - In LOCKED, increments (saturating) each cycle m0_req=1; holds when m0_req=0.
  - When the count equals STARVE_MAX while m0_req=1:
    - that cycle grants M0 regardless of lock (m1_gnt=0);
    - lock_broken=1 for that cycle;
    - next state IDLE_P1, counter cleared.
  - M1 must re-request its lock to re-enter LOCKED.
- Simultaneous lock deassert and starvation in the same cycle: the M0 grant is issued and lock_broken is still pulsed.
- Address and data are passed unmodified; no alignment checks.
- Reset:
  - While reset=0: m0_gnt, m1_gnt, mem_we and lock_broken are forced to 0.
  - rvalid and rdata registers are cleared to 0; state IDLE_P0; counter 0.
  - Reset asserted mid-lock or mid-read drops the lock and any pending rvalid.
  - No memory write may occur during reset.

Test Plan:
1. Reset release, M0 read addr 0x10 with dmem[0x10]=0xDEADBEEF → m0_gnt same cycle, m0_rvalid next cycle with m0_rdata=0xDEADBEEF; mem_we=0 throughout.
2. M0 and M1 request continuously from IDLE_P0 → grants alternate M0, M1, M0, M1; exactly one gnt per cycle.
3. M1 writes 0x12345678 to 0x20 while M0 idles, then M0 reads 0x20 → mem_we high for one cycle only during the M1 grant; M0 read returns 0x12345678.
4. M1 issues a 3-beat locked sequence (m1_lock=1 on beats 1-2, 0 on beat 3) with M0 requesting throughout and STARVE_MAX=16 → three consecutive M1 grants, then M0 granted; lock_broken stays 0.
5. M1 holds m1_lock=1 indefinitely, M0 requests, STARVE_MAX=4 → M1 is granted while M0 is blocked for 4 cycles, then M0 is granted in the next cycle with lock_broken=1 for one cycle; the following arbitration favours M1.
6. Assert reset during LOCKED with a read rvalid pending → all gnt, mem_we, rvalid and rdata are 0 immediately; after release, M0 wins a simultaneous request (state IDLE_P0).

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the dmem pins of the data-memory arbiter.
//
// Handshake: mX_req is a request that the requester holds stable (together with
// mX_we/mX_addr/mX_wdata) until the cycle in which mX_gnt is high. A cycle where
// req and gnt are both high is the cycle the access is performed on the memory
// pins. mX_rvalid is high for exactly the cycle after a read grant; mX_rdata
// keeps its value until the next read for that requester.
interface dmem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req;
  logic          m0_we;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_gnt;
  logic          m0_rvalid;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_lock;
  logic          m1_gnt;
  logic          m1_rvalid;
  logic [DW-1:0] m1_rdata;

  logic          lock_broken;

  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  mem_rdata,
    output m0_gnt, m0_rvalid, m0_rdata,
    output m1_gnt, m1_rvalid, m1_rdata,
    output lock_broken,
    output mem_we, mem_addr, mem_wdata
  );

  // Requester / memory environment side
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output mem_rdata,
    input  m0_gnt, m0_rvalid, m0_rdata,
    input  m1_gnt, m1_rvalid, m1_rdata,
    input  lock_broken,
    input  mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the single-port data memory: CPU (M0) and debug/DMA
// (M1). Round-robin per beat, optional M1 lock for atomic sequences, and a
// starvation guard that breaks the lock once M0 has waited STARVE_MAX cycles.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 16,
  parameter int CW         = 8
) (
  input  logic                 clk,
  input  logic                 reset,            // active-low, asynchronous
  dmem_arbiter_if.slave        bus,
  output logic [1:0]           o_dbg_state,
  output logic [CW-1:0]        o_dbg_starve_cnt
);

  typedef enum logic [1:0] {
    IDLE_P0 = 2'd0,
    IDLE_P1 = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_starve_cnt;
  logic          r_m0_rvalid;
  logic          r_m1_rvalid;
  logic [DW-1:0] r_m0_rdata;
  logic [DW-1:0] r_m1_rdata;

  logic          w_starve;
  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_rd0;
  logic          w_rd1;
  state_t        w_next_state;
  logic [CW-1:0] w_next_cnt;

  // Grant decision: state plus live requests; everything is held low in reset.
  always_comb begin
    w_starve = 1'b0;
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    if (reset) begin
      case (r_state)
        LOCKED: begin
          w_starve = bus.m0_req && (r_starve_cnt == CW'(STARVE_MAX));
          w_gnt0   = w_starve;
          w_gnt1   = bus.m1_req && !w_starve;
        end
        IDLE_P1: begin
          w_gnt1 = bus.m1_req;
          w_gnt0 = bus.m0_req && !bus.m1_req;
        end
        default: begin
          w_gnt0 = bus.m0_req;
          w_gnt1 = bus.m1_req && !bus.m0_req;
        end
      endcase
    end
  end

  // Next state and starvation count; the count only lives inside LOCKED.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOCKED: begin
        if (w_starve)          w_next_state = IDLE_P1;
        else if (!bus.m1_lock) w_next_state = IDLE_P0;
      end
      default: begin
        if (w_gnt0)      w_next_state = IDLE_P1;
        else if (w_gnt1) w_next_state = bus.m1_lock ? LOCKED : IDLE_P0;
      end
    endcase

    w_next_cnt = '0;
    if (w_next_state == LOCKED) begin
      w_next_cnt = r_starve_cnt;
      if (r_state == LOCKED && bus.m0_req && r_starve_cnt != '1)
        w_next_cnt = r_starve_cnt + 1'b1;
    end
  end

  // Arbitration FSM and starvation counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE_P0;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_next_state;
      r_starve_cnt <= w_next_cnt;
    end
  end

  assign w_rd0 = w_gnt0 && !bus.m0_we;
  assign w_rd1 = w_gnt1 && !bus.m1_we;

  // Read return: capture combinational dmem data on a read grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_m0_rvalid <= 1'b0;
      r_m1_rvalid <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_m0_rvalid <= w_rd0;
      r_m1_rvalid <= w_rd1;
      if (w_rd0) r_m0_rdata <= bus.mem_rdata;
      if (w_rd1) r_m1_rdata <= bus.mem_rdata;
    end
  end

  // Memory pins follow the granted master, M0 when nobody is granted.
  assign bus.mem_addr    = w_gnt1 ? bus.m1_addr  : bus.m0_addr;
  assign bus.mem_wdata   = w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
  assign bus.mem_we      = (w_gnt0 && bus.m0_we) || (w_gnt1 && bus.m1_we);

  assign bus.m0_gnt      = w_gnt0;
  assign bus.m1_gnt      = w_gnt1;
  assign bus.lock_broken = w_starve;
  assign bus.m0_rvalid   = r_m0_rvalid;
  assign bus.m1_rvalid   = r_m1_rvalid;
  assign bus.m0_rdata    = r_m0_rdata;
  assign bus.m1_rdata    = r_m1_rdata;

  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then
// randomized traffic, all compared every cycle against a behavioural model.
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int SMAX = 4;
  localparam int CW   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0]    dbg_state;
  logic [CW-1:0] dbg_cnt;

  int n_cmp = 0;
  int n_err = 0;

  dmem_arbiter_if #(.AW(AW), .DW(DW)) bus();

  dmem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX), .CW(CW)) dut (
    .clk              (clk),
    .reset            (rst_n),
    .bus              (bus.slave),
    .o_dbg_state      (dbg_state),
    .o_dbg_starve_cnt (dbg_cnt)
  );

  // clock
  always #5 clk = ~clk;

  // memory environment: 256 words indexed by addr[9:2], combinational read
  logic [DW-1:0] mem    [0:255];
  logic [DW-1:0] shadow [0:255];
  assign bus.mem_rdata = mem[bus.mem_addr[9:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  bit            m_turn1;    // M1 holds round-robin priority
  bit            m_own1;     // M1 owns the memory via its lock
  int            m_blk;      // cycles M0 has waited while M1 owned the memory
  bit            exp_rv0, exp_rv1;
  logic [DW-1:0] exp_rd0, exp_rd1;
  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];
  bit            g0_seen, g1_seen;

  always @(negedge clk) begin : cmp
    bit e0, e1, st, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    if (!rst_n) begin
      m_turn1 = 0; m_own1 = 0; m_blk = 0;
      exp_rd0 = '0; exp_rd1 = '0;
      exp_q0.delete(); exp_q1.delete();
      check("rst_gnt0",    64'(bus.m0_gnt),      64'(0));
      check("rst_gnt1",    64'(bus.m1_gnt),      64'(0));
      check("rst_mem_we",  64'(bus.mem_we),      64'(0));
      check("rst_lb",      64'(bus.lock_broken), 64'(0));
      check("rst_rvalid0", 64'(bus.m0_rvalid),   64'(0));
      check("rst_rvalid1", 64'(bus.m1_rvalid),   64'(0));
      check("rst_rdata0",  64'(bus.m0_rdata),    64'(0));
      check("rst_rdata1",  64'(bus.m1_rdata),    64'(0));
    end else begin
      exp_rv0 = (exp_q0.size() != 0);
      if (exp_rv0) exp_rd0 = exp_q0.pop_front();
      exp_rv1 = (exp_q1.size() != 0);
      if (exp_rv1) exp_rd1 = exp_q1.pop_front();

      st = m_own1 && bus.m0_req && (m_blk == SMAX);
      if (st)                            begin e0 = 1;        e1 = 0;          end
      else if (m_own1)                   begin e0 = 0;        e1 = bus.m1_req; end
      else if (bus.m0_req && bus.m1_req) begin e0 = !m_turn1; e1 = m_turn1;    end
      else                               begin e0 = bus.m0_req; e1 = bus.m1_req; end
      ewe = (e0 && bus.m0_we) || (e1 && bus.m1_we);
      ea  = e1 ? bus.m1_addr  : bus.m0_addr;
      ewd = e1 ? bus.m1_wdata : bus.m0_wdata;

      check("gnt0",      64'(bus.m0_gnt),      64'(e0));
      check("gnt1",      64'(bus.m1_gnt),      64'(e1));
      check("lock_brk",  64'(bus.lock_broken), 64'(st));
      check("mem_we",    64'(bus.mem_we),      64'(ewe));
      check("mem_addr",  64'(bus.mem_addr),    64'(ea));
      check("mem_wdata", 64'(bus.mem_wdata),   64'(ewd));
      check("rvalid0",   64'(bus.m0_rvalid),   64'(exp_rv0));
      check("rvalid1",   64'(bus.m1_rvalid),   64'(exp_rv1));
      check("rdata0",    64'(bus.m0_rdata),    64'(exp_rd0));
      check("rdata1",    64'(bus.m1_rdata),    64'(exp_rd1));

      if (e0 && !bus.m0_we) exp_q0.push_back(shadow[bus.m0_addr[9:2]]);
      if (e1 && !bus.m1_we) exp_q1.push_back(shadow[bus.m1_addr[9:2]]);
      if (ewe) shadow[ea[9:2]] = ewd;

      if (st) begin
        m_own1 = 0; m_turn1 = 1; m_blk = 0;
      end else if (m_own1) begin
        if (!bus.m1_lock) begin m_own1 = 0; m_turn1 = 0; m_blk = 0; end
        else if (bus.m0_req && m_blk < 255) m_blk++;
      end else if (e0) begin
        m_turn1 = 1;
      end else if (e1) begin
        m_turn1 = 0; m_own1 = bus.m1_lock;
      end
    end
    g0_seen = bus.m0_gnt;
    g1_seen = bus.m1_gnt;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_all();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = '0; bus.m0_wdata = '0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = '0; bus.m1_wdata = '0;
    bus.m1_lock = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 0;
    repeat (2) next_cycle();
    rst_n = 1;
  endtask

  task automatic drive_m0(bit req, bit we, logic [AW-1:0] addr, logic [DW-1:0] wd);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wd;
  endtask

  task automatic drive_m1(bit req, bit we, logic [AW-1:0] addr, logic [DW-1:0] wd, bit lock);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wd;
    bus.m1_lock = lock;
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
  endfunction

  // new request only once the previous one has been granted
  task automatic rand_drive(int lock_pct);
    if (!bus.m0_req || g0_seen)
      drive_m0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom);
    if (!bus.m1_req || g1_seen)
      drive_m1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(), $urandom, 1'b0);
    bus.m1_lock = ($urandom_range(0, 99) < lock_pct);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit g1_t5 [7] = '{1, 1, 1, 1, 1, 0, 1};
    bit g0_t5 [7] = '{0, 0, 0, 0, 0, 1, 0};
    int lock_pcts [6] = '{0, 40, 90, 100, 60, 95};

    for (int i = 0; i < 256; i++) begin
      mem[i] = $urandom;
      shadow[i] = mem[i];
    end
    mem[4] = 32'hDEAD_BEEF;
    shadow[4] = 32'hDEAD_BEEF;

    idle_all();
    rst_n = 0;
    repeat (3) next_cycle();
    rst_n = 1;

    // T1: M0 read of 0x10 right after reset
    drive_m0(1, 0, 32'h10, '0);
    @(negedge clk);
    check("t1_gnt0", 64'(bus.m0_gnt), 64'(1));
    check("t1_we",   64'(bus.mem_we), 64'(0));
    next_cycle();
    drive_m0(0, 0, 32'h10, '0);
    @(negedge clk);
    check("t1_rvalid", 64'(bus.m0_rvalid), 64'(1));
    check("t1_rdata",  64'(bus.m0_rdata),  64'h0000_0000_DEAD_BEEF);
    check("t1_we2",    64'(bus.mem_we),    64'(0));
    next_cycle();

    // T2: both masters request continuously from IDLE_P0
    do_reset();
    drive_m0(1, 0, 32'h40, '0);
    drive_m1(1, 0, 32'h44, '0, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_gnt0", 64'(bus.m0_gnt), 64'(i % 2 == 0));
      check("t2_gnt1", 64'(bus.m1_gnt), 64'(i % 2 == 1));
      next_cycle();
    end

    // T3: M1 writes 0x20, then M0 reads it back
    drive_m0(0, 0, 32'h0, '0);
    drive_m1(1, 1, 32'h20, 32'h1234_5678, 0);
    @(negedge clk);
    check("t3_gnt1", 64'(bus.m1_gnt), 64'(1));
    check("t3_we",   64'(bus.mem_we), 64'(1));
    next_cycle();
    drive_m1(0, 0, 32'h0, '0, 0);
    drive_m0(1, 0, 32'h20, '0);
    @(negedge clk);
    check("t3_gnt0", 64'(bus.m0_gnt), 64'(1));
    check("t3_we0",  64'(bus.mem_we), 64'(0));
    next_cycle();
    drive_m0(0, 0, 32'h0, '0);
    @(negedge clk);
    check("t3_rdata", 64'(bus.m0_rdata), 64'h0000_0000_1234_5678);
    next_cycle();

    // T4: 3-beat locked M1 write burst while M0 waits
    drive_m0(1, 0, 32'h30, '0);
    for (int b = 0; b < 3; b++) begin
      drive_m1(1, 1, 32'h80 + 32'(b * 4), 32'hA000_0000 + 32'(b), b < 2);
      @(negedge clk);
      check("t4_gnt1", 64'(bus.m1_gnt),      64'(1));
      check("t4_gnt0", 64'(bus.m0_gnt),      64'(0));
      check("t4_lb",   64'(bus.lock_broken), 64'(0));
      next_cycle();
    end
    drive_m1(0, 0, 32'h0, '0, 0);
    @(negedge clk);
    check("t4_gnt0_after", 64'(bus.m0_gnt),      64'(1));
    check("t4_lb_after",   64'(bus.lock_broken), 64'(0));
    next_cycle();

    // T5: M1 holds its lock forever; starvation guard breaks it
    drive_m0(1, 0, 32'h34, '0);
    drive_m1(1, 0, 32'h90, '0, 1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      check("t5_gnt1", 64'(bus.m1_gnt),      64'(g1_t5[c]));
      check("t5_gnt0", 64'(bus.m0_gnt),      64'(g0_t5[c]));
      check("t5_lb",   64'(bus.lock_broken), 64'(g0_t5[c]));
      next_cycle();
    end

    // T6: reset while LOCKED with an M1 read return in flight
    check("t6_pre_rvalid1", 64'(bus.m1_rvalid), 64'(1));
    bus.m1_we = 1;
    rst_n = 0;
    #1;
    check("t6_gnt0",    64'(bus.m0_gnt),    64'(0));
    check("t6_gnt1",    64'(bus.m1_gnt),    64'(0));
    check("t6_we",      64'(bus.mem_we),    64'(0));
    check("t6_rvalid1", 64'(bus.m1_rvalid), 64'(0));
    check("t6_rdata1",  64'(bus.m1_rdata),  64'(0));
    check("t6_rdata0",  64'(bus.m0_rdata),  64'(0));
    repeat (2) next_cycle();
    rst_n = 1;
    @(negedge clk);
    check("t6_post_gnt0", 64'(bus.m0_gnt), 64'(1));
    check("t6_post_gnt1", 64'(bus.m1_gnt), 64'(0));
    next_cycle();

    // Random traffic in episodes of varying lock pressure
    for (int ep = 0; ep < 6; ep++) begin
      if ($urandom_range(0, 1) == 1) do_reset();
      for (int c = 0; c < 400; c++) begin
        rand_drive(lock_pcts[ep]);
        next_cycle();
      end
    end
    idle_all();
    repeat (3) next_cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
